// File: rtl/opl_csr_pkg.sv
// rtl/opl_csr_pkg.sv - shared constants and word layout for the OPL operator-config store
package opl_csr_pkg;

    localparam int OPL_SLOTS   = 18;
    localparam int OPL_OPCFG_W = 32;

    localparam int MULT_LANE  = 3;
    localparam int KSLTL_LANE = 2;
    localparam int ARDR_LANE  = 1;
    localparam int SLRR_LANE  = 0;

    typedef struct packed {
        logic       am;
        logic       vib;
        logic       en_sus;
        logic       ks;
        logic [3:0] mul;
        logic [1:0] ksl;
        logic [5:0] tl;
        logic [3:0] ar;
        logic [3:0] dr;
        logic [3:0] sl;
        logic [3:0] rr;
    } opcfg_t;

endpackage

// File: rtl/opl_op_csr_if.sv
// rtl/opl_op_csr_if.sv - CPU register-write strobes and slot-stage matches into the config store
interface opl_op_csr_if;

    logic [7:0] din;
    logic       up_mult;
    logic       up_ksl_tl;
    logic       up_ar_dr;
    logic       up_sl_rr;
    logic       update_op_I;
    logic       update_op_II;
    logic       update_op_IV;

    modport master (
        output din, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr,
        output update_op_I, update_op_II, update_op_IV
    );

    modport slave (
        input din, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr,
        input update_op_I, update_op_II, update_op_IV
    );

endinterface

// File: rtl/opl_op_csr_sh_line.sv
// rtl/opl_op_csr_sh_line.sv - generic W x LEN shift line with clock enable and sync reset
// OPL_CSR_SIM_INIT_EN gives every stage a time-zero value of RSTVAL for simulation.
module opl_sh_line #(
    parameter int W      = 32,
    parameter int LEN    = 18,
    parameter bit RSTVAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic [W-1:0] din,
    output logic [W-1:0] drop
);

`ifdef OPL_CSR_SIM_INIT_EN
    logic [W-1:0] stage [LEN] = '{default: {W{RSTVAL}}};
`else
    logic [W-1:0] stage [LEN];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LEN; i++) stage[i] <= {W{RSTVAL}};
        end else if (cen) begin
            stage[0] <= din;
            for (int i = 1; i < LEN; i++) stage[i] <= stage[i-1];
        end
    end

    assign drop = stage[LEN-1];

endmodule

// File: rtl/opl_op_csr.sv
// rtl/opl_op_csr.sv - recirculating per-slot operator config store with byte-lane write merge
// OPL_CSR_SIM_INIT_EN (in opl_sh_line) selects time-zero stage initialisation.
module opl_op_csr
    import opl_csr_pkg::*;
#(
    parameter int LEN    = OPL_SLOTS,
    parameter int W      = OPL_OPCFG_W,
    parameter bit RSTVAL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    opl_op_csr_if.slave  wr,
    output logic [W-1:0] shift_out
);

    logic [W-1:0] next_word;

    // MULT is consumed at stage II and TL at stage IV, so each lane has its own match strobe.
    always_comb begin
        next_word = shift_out;
        if (wr.up_mult   && wr.update_op_II) next_word[MULT_LANE*8  +: 8] = wr.din;
        if (wr.up_ksl_tl && wr.update_op_IV) next_word[KSLTL_LANE*8 +: 8] = wr.din;
        if (wr.up_ar_dr  && wr.update_op_I)  next_word[ARDR_LANE*8  +: 8] = wr.din;
        if (wr.up_sl_rr  && wr.update_op_I)  next_word[SLRR_LANE*8  +: 8] = wr.din;
    end

    opl_sh_line #(
        .W      (W),
        .LEN    (LEN),
        .RSTVAL (RSTVAL)
    ) u_line (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .din  (next_word),
        .drop (shift_out)
    );

endmodule

// File: tb/tb_opl_op_csr.sv
// tb/tb_opl_op_csr.sv - directed table-driven bench for opl_op_csr
module tb_opl_op_csr;

    localparam int LEN = 18;

    logic        clk;
    logic        rst;
    logic        cen;
    logic [31:0] shift_out;

    opl_op_csr_if bus ();

    opl_op_csr #(.LEN(LEN), .W(32), .RSTVAL(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .wr        (bus.slave),
        .shift_out (shift_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  din;
        logic [3:0]  up;   // {mult, ksl_tl, ar_dr, sl_rr}
        logic [2:0]  upd;  // {I, II, IV}
        logic [31:0] exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: shift_out=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [7:0] d, input logic [3:0] up, input logic [2:0] upd);
        bus.din          = d;
        bus.up_mult      = up[3];
        bus.up_ksl_tl    = up[2];
        bus.up_ar_dr     = up[1];
        bus.up_sl_rr     = up[0];
        bus.update_op_I  = upd[2];
        bus.update_op_II = upd[1];
        bus.update_op_IV = upd[0];
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{8'hA5, 4'b1000, 3'b010, 32'hA500_0000};
        vecs[1] = '{8'h3F, 4'b0100, 3'b100, 32'h0000_0000};
        vecs[2] = '{8'h3F, 4'b0100, 3'b001, 32'h003F_0000};
        vecs[3] = '{8'hF2, 4'b0011, 3'b100, 32'h0000_F2F2};
        vecs[4] = '{8'h77, 4'b1000, 3'b100, 32'h0000_0000};
        vecs[5] = '{8'h5C, 4'b1111, 3'b111, 32'h5C5C_5C5C};
        vecs[6] = '{8'h12, 4'b0000, 3'b111, 32'h0000_0000};
        vecs[7] = '{8'h99, 4'b0001, 3'b001, 32'h0000_0000};

        rst = 1'b1;
        cen = 1'b1;
        set_wr(8'h00, 4'b0000, 3'b000);

        // Reset after free running, then the line must stay empty.
        repeat (40) tick();
        do_reset();
        check("reset_value", shift_out, 32'h0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("reset_hold", shift_out, 32'h0);
        end

        // One write per row from an empty line; target slot, neighbour, next period.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            set_wr(vecs[i].din, vecs[i].up, vecs[i].upd);
            tick();
            set_wr(8'h00, 4'b0000, 3'b000);
            repeat (LEN - 1) tick();
            check($sformatf("vec%0d_first", i), shift_out, vecs[i].exp);
            tick();
            check($sformatf("vec%0d_neighbour", i), shift_out, 32'h0);
            repeat (LEN - 1) tick();
            check($sformatf("vec%0d_second", i), shift_out, vecs[i].exp);
        end

        // Second AR/DR write merges into the recirculating slot, SL/RR preserved.
        do_reset();
        set_wr(8'hF2, 4'b0011, 3'b100);
        tick();
        set_wr(8'h00, 4'b0000, 3'b000);
        repeat (LEN - 1) tick();
        check("merge_first", shift_out, 32'h0000_F2F2);
        set_wr(8'h11, 4'b0010, 3'b100);
        tick();
        set_wr(8'h00, 4'b0000, 3'b000);
        repeat (LEN - 1) tick();
        check("merge_second", shift_out, 32'h0000_11F2);

        // cen stall: line frozen for 50 clocks, write still lands after 18 cen ticks total.
        do_reset();
        set_wr(8'hC3, 4'b1000, 3'b010);
        tick();
        set_wr(8'h00, 4'b0000, 3'b000);
        repeat (5) tick();
        cen = 1'b0;
        set_wr(8'hEE, 4'b1111, 3'b111);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("stall_hold", shift_out, 32'h0);
        end
        set_wr(8'h00, 4'b0000, 3'b000);
        cen = 1'b1;
        repeat (LEN - 1 - 5 - 1) tick();
        check("stall_before", shift_out, 32'h0);
        tick();
        check("stall_land", shift_out, 32'hC300_0000);

        // Load five slots, then reset with cen low while a write is strobed.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_wr(8'(k + 1), 4'b1000, 3'b010);
            tick();
        end
        set_wr(8'h00, 4'b0000, 3'b000);
        repeat (LEN - 5) tick();
        check("midrst_loaded", shift_out, 32'h0100_0000);
        tick();
        check("midrst_loaded2", shift_out, 32'h0200_0000);
        rst = 1'b0;
        cen = 1'b0;
        set_wr(8'hFF, 4'b1111, 3'b111);
        tick();
        check("midrst_zero", shift_out, 32'h0);
        rst = 1'b1;
        cen = 1'b1;
        set_wr(8'h00, 4'b0000, 3'b000);
        for (int i = 0; i < 2 * LEN; i++) begin
            tick();
            check("midrst_clear", shift_out, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
